calc_sequencer: RTL and testbench

//  Command-side driver for the 4-bit combinational calculator (OP/A/B -> R/ovf).

---
 rtl/calc_sequencer_if.sv | 25 ++
 rtl/calc_sequencer.sv | 135 +++++++++++++
 tb/tb_calc_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// Command and result handshake bundle between a producer/consumer and calc_sequencer.
interface calc_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_chain;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
    input  cmd_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, res_ready,
    output cmd_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/calc_sequencer.sv
// Drives a combinational 4-bit calculator from a valid/ready command port and returns
// its registered result, with a chaining accumulator and overflow bookkeeping.
module calc_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  calc_sequencer_if.slave      bus,
  input  logic                 clr,
  output logic [2:0]           calc_op,
  output logic [WIDTH-1:0]     calc_a,
  output logic [WIDTH-1:0]     calc_b,
  input  logic [WIDTH-1:0]     calc_r,
  input  logic                 calc_ovf,
  output logic [WIDTH-1:0]     acc,
  output logic                 ovf_sticky,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 res_valid_q, res_valid_d;
  logic [2:0]           calc_op_q, calc_op_d;
  logic [WIDTH-1:0]     calc_a_q, calc_a_d;
  logic [WIDTH-1:0]     calc_b_q, calc_b_d;
  logic [WIDTH-1:0]     res_data_q, res_data_d;
  logic                 res_ovf_q, res_ovf_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic [OVF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 accept;

  // Handshake flags are registered so they read 0 while reset is held and
  // cmd_ready rises only on the first edge after release.
  assign accept = bus.cmd_valid && cmd_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   state_d = RESP;
      RESP:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    res_valid_d = (state_d == RESP);
    calc_op_d   = calc_op_q;
    calc_a_d    = calc_a_q;
    calc_b_d    = calc_b_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    if (state_q == IDLE && accept) begin
      calc_op_d = bus.cmd_op;
      calc_a_d  = bus.cmd_chain ? acc_q : bus.cmd_a;
      calc_b_d  = bus.cmd_b;
    end

    if (state_q == DRIVE) begin
      res_data_d = calc_r;
      res_ovf_d  = calc_ovf;
      acc_d      = calc_r;
      if (calc_ovf) begin
        sticky_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end

    // clr wins over capture for the bookkeeping only; the result path is untouched.
    if (clr) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      calc_op_q   <= '0;
      calc_a_q    <= '0;
      calc_b_q    <= '0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      calc_op_q   <= calc_op_d;
      calc_a_q    <= calc_a_d;
      calc_b_q    <= calc_b_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign calc_op       = calc_op_q;
  assign calc_a        = calc_a_q;
  assign calc_b        = calc_b_q;
  assign acc           = acc_q;
  assign ovf_sticky    = sticky_q;
  assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural 4-bit calculator on its outputs.
module tb_calc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [2:0] calc_op;
  logic [3:0] calc_a, calc_b, calc_r, acc;
  logic       calc_ovf, ovf_sticky;
  logic [1:0] ovf_count;

  int tests;
  int fails;

  calc_sequencer_if #(.WIDTH(4)) bus ();

  calc_sequencer #(.WIDTH(4), .OVF_CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .clr        (clr),
    .calc_op    (calc_op),
    .calc_a     (calc_a),
    .calc_b     (calc_b),
    .calc_r     (calc_r),
    .calc_ovf   (calc_ovf),
    .acc        (acc),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two's-complement calculator the sequencer is meant to drive.
  function automatic logic [4:0] calc_model(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
    logic [3:0] r;
    logic       v;
    r = '0;
    v = 1'b0;
    case (op)
      3'b000: begin r = a + b; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'b001: begin r = a - b; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'b010, 3'b011: begin r = b[3] ? (~b + 4'd1) : b; v = (b == 4'b1000); end
      3'b100: begin r = b + a; v = (a[3] == b[3]) && (r[3] != b[3]); end
      3'b101: begin r = b - a; v = (b[3] != a[3]) && (r[3] != b[3]); end
      default: begin r = a[3] ? (~a + 4'd1) : a; v = (a == 4'b1000); end
    endcase
    return {v, r};
  endfunction

  assign {calc_ovf, calc_r} = calc_model(calc_op, calc_a, calc_b);

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       chain;
    logic [3:0] exp_calc_a;
    logic [3:0] exp_data;
    logic       exp_ovf;
    logic [3:0] exp_acc;
    logic       exp_sticky;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full transaction starting and ending at a negedge in IDLE.
  task automatic xact(input string tag, input vec_t v, input logic do_clr);
    check({tag, ".ready_in"}, {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_chain = v.chain;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_chain = 1'b0;
    clr           = do_clr;
    check({tag, ".calc_op"}, {29'd0, calc_op}, {29'd0, v.op});
    check({tag, ".calc_a"}, {28'd0, calc_a}, {28'd0, v.exp_calc_a});
    check({tag, ".calc_b"}, {28'd0, calc_b}, {28'd0, v.b});
    check({tag, ".drive_hs"}, {30'd0, bus.cmd_ready, bus.res_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    check({tag, ".res_valid"}, {31'd0, bus.res_valid}, 32'd1);
    check({tag, ".res_data"}, {28'd0, bus.res_data}, {28'd0, v.exp_data});
    check({tag, ".res_ovf"}, {31'd0, bus.res_ovf}, {31'd0, v.exp_ovf});
    check({tag, ".acc"}, {28'd0, acc}, {28'd0, v.exp_acc});
    check({tag, ".sticky"}, {31'd0, ovf_sticky}, {31'd0, v.exp_sticky});
    check({tag, ".count"}, {30'd0, ovf_count}, {30'd0, v.exp_cnt});
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, ".idle_hs"}, {30'd0, bus.cmd_ready, bus.res_valid}, 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    logic [3:0] held;

    tests = 0;
    fails = 0;
    //          op      a      b      ch    calc_a data   ovf   acc    st    cnt
    vecs[0] = '{3'b000, 4'h3, 4'h4, 1'b0, 4'h3, 4'h7, 1'b0, 4'h7, 1'b0, 2'd0};
    vecs[1] = '{3'b000, 4'h7, 4'h1, 1'b0, 4'h7, 4'h8, 1'b1, 4'h8, 1'b1, 2'd1};
    vecs[2] = '{3'b011, 4'h0, 4'h8, 1'b0, 4'h0, 4'h8, 1'b1, 4'h8, 1'b1, 2'd2};
    vecs[3] = '{3'b110, 4'hD, 4'h0, 1'b0, 4'hD, 4'h3, 1'b0, 4'h3, 1'b1, 2'd2};
    vecs[4] = '{3'b000, 4'h2, 4'h1, 1'b0, 4'h2, 4'h3, 1'b0, 4'h3, 1'b1, 2'd2};
    vecs[5] = '{3'b101, 4'hF, 4'h1, 1'b1, 4'h3, 4'hE, 1'b0, 4'hE, 1'b1, 2'd2};
    vecs[6] = '{3'b001, 4'h8, 4'h1, 1'b0, 4'h8, 4'h7, 1'b1, 4'h7, 1'b1, 2'd3};
    vecs[7] = '{3'b100, 4'h1, 4'h2, 1'b0, 4'h1, 4'h3, 1'b0, 4'h3, 1'b1, 2'd3};
    vecs[8] = '{3'b001, 4'h5, 4'h7, 1'b0, 4'h5, 4'hE, 1'b0, 4'hE, 1'b1, 2'd3};
    vecs[9] = '{3'b000, 4'h4, 4'h4, 1'b0, 4'h4, 4'h8, 1'b1, 4'h8, 1'b1, 2'd3};

    rst_n         = 1'b1;
    clr           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_chain = 1'b0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset.outputs",
          {14'd0, bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_ovf, calc_op, acc,
           ovf_sticky, ovf_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset.ready_low_at_release", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset.ready_after_edge", {31'd0, bus.cmd_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      xact($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // Overflowing op with clr during DRIVE: bookkeeping clears, result still captured.
    v = '{3'b000, 4'h6, 4'h6, 1'b0, 4'h6, 4'hC, 1'b1, 4'h0, 1'b0, 2'd0};
    xact("clr_drive", v, 1'b1);

    // Backpressure: result held 5 cycles while a competing command is presented.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b001;
    bus.cmd_a     = 4'h3;
    bus.cmd_b     = 4'h5;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_a = 4'h1;
    @(posedge clk);
    @(negedge clk);
    held = bus.res_data;
    check("bp.first_data", {28'd0, held}, 32'hE);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.data_c%0d", c), {28'd0, bus.res_data}, 32'hE);
      check($sformatf("bp.hs_c%0d", c), {30'd0, bus.cmd_ready, bus.res_valid}, 32'd1);
      check($sformatf("bp.calc_a_c%0d", c), {28'd0, calc_a}, 32'h3);
      @(posedge clk);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    check("bp.ready_still_low", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("bp.ready_returns", {31'd0, bus.cmd_ready}, 32'd1);

    // Async reset while a result is pending in RESP.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 4'h1;
    bus.cmd_b     = 4'h1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid.pre_valid", {27'd0, bus.res_valid, bus.res_data}, 32'h12);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.outputs",
          {10'd0, bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_ovf, calc_op, calc_a,
           calc_b, acc[0], ovf_sticky, ovf_count}, 32'd0);
    check("rst_mid.acc", {28'd0, acc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid.ready_after", {30'd0, bus.cmd_ready, bus.res_valid}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
